// File: rtl/cpu_sequencer.sv
// Multi-cycle load/add/store sequencer over a synchronous single-port memory.
// Optional CPU_SEQUENCER_CARRY_EN adds a carry flag updated by ADD write-back.
module cpu_sequencer #(
    parameter logic [7:0] RESET_PC = 8'd20,
    parameter logic [7:0] MEM_TOP  = 8'd127
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  MAR,
    output logic        EN,
    output logic        CS,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        halted,
    output logic        error,
    output logic [7:0]  pc,
    output logic [15:0] instr_count,
`ifdef CPU_SEQUENCER_CARRY_EN
    output logic        carry,
`endif
    input  logic [1:0]  dbg_sel,
    output logic [15:0] dbg_value
);

    typedef enum logic [2:0] {
        StIdle, StFetch, StFwait, StDecode, StExec, StEwait, StWb, StHalt
    } state_e;

    localparam logic [3:0] OpLoad  = 4'h3;
    localparam logic [3:0] OpAdd   = 4'h7;
    localparam logic [3:0] OpStore = 4'hB;
    localparam logic [3:0] OpHalt  = 4'hF;

    state_e            state_q, state_d;
    logic [7:0]        pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [3:0][15:0]  rf_q, rf_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              halted_q, halted_d;
    logic              error_q, error_d;
    logic              en_q, en_d;
    logic              cs_q, cs_d;
    logic [7:0]        mar_q, mar_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              fetch_req;
    logic              op_legal;

    logic [3:0] op;
    logic [1:0] sel;
    logic [7:0] addr;

    assign op   = ir_q[15:12];
    assign sel  = ir_q[9:8];
    assign addr = ir_q[7:0];

`ifdef CPU_SEQUENCER_CARRY_EN
    logic        carry_q, carry_d;
    logic [16:0] add_sum;
    assign add_sum = {1'b0, rf_q[sel]} + {1'b0, mem_rdata};
`else
    logic [15:0] add_sum;
    assign add_sum = rf_q[sel] + mem_rdata;
`endif

    always_comb begin
        op_legal = 1'b0;
        case (op)
            OpLoad, OpAdd, OpStore, OpHalt: op_legal = 1'b1;
            default:                        op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        rf_d      = rf_q;
        cnt_d     = cnt_q;
        halted_d  = halted_q;
        error_d   = error_q;
        en_d      = 1'b0;
        cs_d      = 1'b0;
        mar_d     = mar_q;
        wdata_d   = wdata_q;
        fetch_req = 1'b0;
`ifdef CPU_SEQUENCER_CARRY_EN
        carry_d   = carry_q;
`endif

        case (state_q)
            StIdle: begin
                if (start) fetch_req = 1'b1;
            end
            StFetch: state_d = StFwait;
            StFwait: begin
                ir_d    = mem_rdata;
                state_d = StDecode;
            end
            StDecode: begin
                pc_d = pc_q + 8'd1;
                if (!op_legal || ir_q[11:10] != 2'b00) begin
                    state_d  = StHalt;
                    halted_d = 1'b1;
                    error_d  = 1'b1;
                end else if (op == OpHalt) begin
                    state_d  = StHalt;
                    halted_d = 1'b1;
                end else if (addr > MEM_TOP) begin
                    state_d  = StHalt;
                    halted_d = 1'b1;
                    error_d  = 1'b1;
                end else begin
                    state_d = StExec;
                    en_d    = 1'b1;
                    mar_d   = addr;
                    if (op == OpStore) begin
                        cs_d    = 1'b1;
                        wdata_d = rf_q[sel];
                    end
                end
            end
            StExec: begin
                if (op == OpStore) begin
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                    fetch_req = 1'b1;
                end else begin
                    state_d = StEwait;
                end
            end
            StEwait: state_d = StWb;
            StWb: begin
                if (op == OpLoad) begin
                    rf_d[sel] = mem_rdata;
                end else begin
                    rf_d[sel] = add_sum[15:0];
`ifdef CPU_SEQUENCER_CARRY_EN
                    carry_d   = add_sum[16];
`endif
                end
                if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                fetch_req = 1'b1;
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase

        // An out-of-range fetch stops here so EN is never raised for it.
        if (fetch_req) begin
            if (pc_q > MEM_TOP) begin
                state_d  = StHalt;
                halted_d = 1'b1;
                error_d  = 1'b1;
            end else begin
                state_d = StFetch;
                en_d    = 1'b1;
                cs_d    = 1'b0;
                mar_d   = pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            ir_q     <= 16'h0000;
            rf_q     <= '0;
            cnt_q    <= 16'h0000;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
            en_q     <= 1'b0;
            cs_q     <= 1'b0;
            mar_q    <= 8'h00;
            wdata_q  <= 16'h0000;
`ifdef CPU_SEQUENCER_CARRY_EN
            carry_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            rf_q     <= rf_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            error_q  <= error_d;
            en_q     <= en_d;
            cs_q     <= cs_d;
            mar_q    <= mar_d;
            wdata_q  <= wdata_d;
`ifdef CPU_SEQUENCER_CARRY_EN
            carry_q  <= carry_d;
`endif
        end
    end

    assign MAR         = mar_q;
    assign EN          = en_q;
    assign CS          = cs_q;
    assign mem_wdata   = wdata_q;
    assign halted      = halted_q;
    assign error       = error_q;
    assign pc          = pc_q;
    assign instr_count = cnt_q;
    assign dbg_value   = rf_q[dbg_sel];
`ifdef CPU_SEQUENCER_CARRY_EN
    assign carry       = carry_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer with a synchronous memory model.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  MAR;
    logic        EN;
    logic        CS;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        halted;
    logic        error;
    logic [7:0]  pc;
    logic [15:0] instr_count;
    logic [1:0]  dbg_sel;
    logic [15:0] dbg_value;
`ifdef CPU_SEQUENCER_CARRY_EN
    logic        carry;
`endif

    logic [15:0] mem [256];
    logic        tb_we;
    logic [7:0]  tb_addr;
    logic [15:0] tb_data;

    int n_checks = 0;
    int n_pass   = 0;
    int edges;
    int en_cnt;
    logic [15:0] rv;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .MAR         (MAR),
        .EN          (EN),
        .CS          (CS),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .halted      (halted),
        .error       (error),
        .pc          (pc),
        .instr_count (instr_count),
`ifdef CPU_SEQUENCER_CARRY_EN
        .carry       (carry),
`endif
        .dbg_sel     (dbg_sel),
        .dbg_value   (dbg_value)
    );

    // Memory: sampled EN/CS/MAR act on the edge; read data holds until next read.
    always @(posedge clk) begin
        if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end else if (EN) begin
            if (CS) mem[MAR] <= mem_wdata;
            else    mem_rdata <= mem[MAR];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic mem_wr(input logic [7:0] a, input logic [15:0] d);
        tb_addr = a;
        tb_data = d;
        tb_we   = 1'b1;
        @(posedge clk); #1;
        tb_we   = 1'b0;
    endtask

    // Hold the DUT in reset and zero the memory.
    task automatic prog_begin();
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 256; i++) mem_wr(i[7:0], 16'h0000);
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic get_reg(input logic [1:0] i, output logic [15:0] v);
        dbg_sel = i;
        #1;
        v = dbg_value;
    endtask

    task automatic run(output int n_edges, output int n_en);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_edges = 0;
        n_en = 0;
        while (!halted && n_edges < 2000) begin
            if (EN) n_en++;
            @(posedge clk); #1;
            n_edges++;
        end
    endtask

    task automatic load_prog1(input logic [15:0] a30);
        mem_wr(8'd20, 16'h311E);
        mem_wr(8'd21, 16'h711F);
        mem_wr(8'd22, 16'hB120);
        mem_wr(8'd23, 16'hF000);
        mem_wr(8'd30, a30);
        mem_wr(8'd31, 16'h0008);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        dbg_sel = 2'd0;
        tb_we   = 1'b0;
        tb_addr = 8'h00;
        tb_data = 16'h0000;

        // Reset state and the reference program
        prog_begin();
        load_prog1(16'h0005);
        release_reset();
        check("rst_pc", pc, 8'd20);
        check("rst_halted", halted, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_en", EN, 1'b0);
        check("rst_cs", CS, 1'b0);
        check("rst_mar", MAR, 8'h00);
        check("rst_wdata", mem_wdata, 16'h0000);
        check("rst_count", instr_count, 16'h0000);
        get_reg(2'd1, rv);
        check("rst_r1", rv, 16'h0000);
        run(edges, en_cnt);
        check("p1_edges", edges, 19);
        check("p1_en_cycles", en_cnt, 7);
        check("p1_mem32", mem[32], 16'h000D);
        get_reg(2'd1, rv);
        check("p1_r1", rv, 16'd13);
        check("p1_count", instr_count, 16'd3);
        check("p1_error", error, 1'b0);
        check("p1_pc", pc, 8'd24);

        // start in HALT is ignored
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("hlt_halted", halted, 1'b1);
        check("hlt_pc", pc, 8'd24);
        check("hlt_en", EN, 1'b0);
        check("hlt_count", instr_count, 16'd3);

        // Re-run after reset with a different operand
        reset = 1'b1;
        mem_wr(8'd30, 16'h0007);
        release_reset();
        check("rr_pc", pc, 8'd20);
        check("rr_halted", halted, 1'b0);
        run(edges, en_cnt);
        check("rr_edges", edges, 19);
        check("rr_mem32", mem[32], 16'h000F);
        get_reg(2'd1, rv);
        check("rr_r1", rv, 16'h000F);

        // ADD wrap with carry
        prog_begin();
        mem_wr(8'd20, 16'h3220);
        mem_wr(8'd21, 16'h7221);
        mem_wr(8'd22, 16'hF000);
        mem_wr(8'h20, 16'hFFFF);
        mem_wr(8'h21, 16'h0001);
        release_reset();
        run(edges, en_cnt);
        check("add_edges", edges, 15);
        get_reg(2'd2, rv);
        check("add_r2", rv, 16'h0000);
        check("add_count", instr_count, 16'd2);
        check("add_pc", pc, 8'd23);
`ifdef CPU_SEQUENCER_CARRY_EN
        check("add_carry", carry, 1'b1);
`endif

        // Illegal opcode
        prog_begin();
        release_reset();
        run(edges, en_cnt);
        check("ill_edges", edges, 3);
        check("ill_en_cycles", en_cnt, 1);
        check("ill_error", error, 1'b1);
        check("ill_pc", pc, 8'd21);
        check("ill_count", instr_count, 16'd0);

        // Nonzero upper register bits
        prog_begin();
        mem_wr(8'd20, 16'h3400);
        release_reset();
        run(edges, en_cnt);
        check("reg_edges", edges, 3);
        check("reg_error", error, 1'b1);

        // Operand address above MEM_TOP on a STORE
        prog_begin();
        mem_wr(8'd20, 16'hB180);
        mem_wr(8'h80, 16'h1234);
        release_reset();
        run(edges, en_cnt);
        check("oob_edges", edges, 3);
        check("oob_en_cycles", en_cnt, 1);
        check("oob_error", error, 1'b1);
        check("oob_mem80", mem[8'h80], 16'h1234);

        // Reset in the DECODE cycle of a STORE
        prog_begin();
        mem_wr(8'd20, 16'hB11E);
        mem_wr(8'h1E, 16'hABCD);
        release_reset();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_en", EN, 1'b0);
        check("mid_pc", pc, 8'd20);
        repeat (3) @(posedge clk);
        #1;
        check("mid_mem1e", mem[8'h1E], 16'hABCD);
        check("mid_idle_en", EN, 1'b0);
        check("mid_idle_pc", pc, 8'd20);

        // Running off the top of memory stops on the fetch
        prog_begin();
        for (int a = 20; a < 128; a++) mem_wr(a[7:0], 16'hB000);
        release_reset();
        run(edges, en_cnt);
        check("top_edges", edges, 432);
        check("top_en_cycles", en_cnt, 216);
        check("top_pc", pc, 8'd128);
        check("top_error", error, 1'b1);
        check("top_count", instr_count, 16'd108);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
